// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core front end: opcodes, bubble word,
// fetch FSM states and the B-type immediate decoder.
package core_pkg;

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    MISS = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds on stall, loads a bubble on squash,
// otherwise captures the fetched word together with its PC.
module if_id_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hold,
  input  logic        i_squash,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inst  <= NOP_INST;
      r_pc    <= 32'h0;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      // The PC is kept on a squash so the bubble can still be traced.
      r_inst  <= i_squash ? NOP_INST : i_inst;
      r_pc    <= i_pc;
      r_valid <= !i_squash;
    end
  end

  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch FSM, conditional-branch
// pre-decode for the predictor, IF/ID fill/squash and branch statistics.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = core_pkg::NOP_INST,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      ic_addr,
  output logic             ic_req,
  input  logic [31:0]      ic_rdata,
  input  logic             ic_stall,
  input  logic             hazard_stall,
  input  logic [31:0]      bp_pc_next,
  input  logic             bp_correct,
  output logic             branch_if,
  output logic             branch_id,
  output logic [31:0]      pc_add_4,
  output logic [31:0]      pc_add_imm,
  output logic             stall_out,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc,
  output logic             id_valid,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  import core_pkg::*;

  fetch_state_t     r_state;
  fetch_state_t     w_state_next;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mis_cnt;
  logic             w_fetching;
  logic             w_advance;
  logic             w_squash;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOT:    w_state_next = RUN;
      RUN:     if (ic_stall) w_state_next = MISS;
      MISS:    if (!ic_stall) w_state_next = RUN;
      default: w_state_next = BOOT;
    endcase
  end

  // The cache word is only meaningful once out of BOOT and not missing.
  assign w_fetching = ((r_state == RUN) || (r_state == MISS)) && !ic_stall;
  assign w_advance  = w_fetching && !hazard_stall;
  assign w_squash   = branch_id && !bp_correct;

  assign branch_if  = w_fetching && (ic_rdata[6:0] == OP_BRANCH);
  assign pc_add_4   = r_pc + 32'd4;
  assign pc_add_imm = r_pc + imm_b(ic_rdata);
  assign stall_out  = ic_stall || hazard_stall || (r_state != RUN);
  assign ic_addr    = r_pc;
  assign ic_req     = rst_n;
  assign branch_id  = id_valid && (id_inst[6:0] == OP_BRANCH);

  always_ff @(posedge clk) begin
    if (!rst_n)         r_pc <= RESET_PC;
    else if (w_advance) r_pc <= bp_pc_next;
  end

  // A mispredict seen under hazard_stall is left for the cycle the stall drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (w_advance && branch_id) begin
      if (r_br_cnt != '1) r_br_cnt <= r_br_cnt + 1'b1;
      if (!bp_correct && (r_mis_cnt != '1)) r_mis_cnt <= r_mis_cnt + 1'b1;
    end
  end

  assign br_cnt  = r_br_cnt;
  assign mis_cnt = r_mis_cnt;

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_hold  (!w_advance),
    .i_squash(w_squash),
    .i_inst  (ic_rdata),
    .i_pc    (r_pc),
    .o_inst  (id_inst),
    .o_pc    (id_pc),
    .o_valid (id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; a second narrow-counter instance shares the
// stimulus so counter saturation is reached within a short run.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W0  = 32'h0010_0093;
  localparam logic [31:0] W1  = 32'h0020_0113;
  localparam logic [31:0] W2  = 32'h0030_0193;
  localparam logic [31:0] W3  = 32'h0040_0213;
  localparam logic [31:0] W4  = 32'h0050_0293;
  localparam logic [31:0] W5  = 32'h0060_0313;
  localparam logic [31:0] BEQ = 32'h0200_0063;  // beq x0,x0,+0x20
  localparam logic [31:0] JNK = 32'hFFFF_FFE3;  // branch opcode on a miss

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ic_rdata;
  logic        ic_stall;
  logic        hazard_stall;
  logic [31:0] bp_pc_next;
  logic        bp_correct;

  logic [31:0] ic_addr, pc_add_4, pc_add_imm, id_inst, id_pc;
  logic        ic_req, branch_if, branch_id, stall_out, id_valid;
  logic [15:0] br_cnt, mis_cnt;

  logic [31:0] s_ic_addr, s_pc_add_4, s_pc_add_imm, s_id_inst, s_id_pc;
  logic        s_ic_req, s_branch_if, s_branch_id, s_stall_out, s_id_valid;
  logic [1:0]  s_br_cnt, s_mis_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ic_addr(ic_addr), .ic_req(ic_req),
    .ic_rdata(ic_rdata), .ic_stall(ic_stall), .hazard_stall(hazard_stall),
    .bp_pc_next(bp_pc_next), .bp_correct(bp_correct), .branch_if(branch_if),
    .branch_id(branch_id), .pc_add_4(pc_add_4), .pc_add_imm(pc_add_imm),
    .stall_out(stall_out), .id_inst(id_inst), .id_pc(id_pc),
    .id_valid(id_valid), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ic_addr(s_ic_addr), .ic_req(s_ic_req),
    .ic_rdata(ic_rdata), .ic_stall(ic_stall), .hazard_stall(hazard_stall),
    .bp_pc_next(bp_pc_next), .bp_correct(bp_correct), .branch_if(s_branch_if),
    .branch_id(s_branch_id), .pc_add_4(s_pc_add_4), .pc_add_imm(s_pc_add_imm),
    .stall_out(s_stall_out), .id_inst(s_id_inst), .id_pc(s_id_pc),
    .id_valid(s_id_valid), .br_cnt(s_br_cnt), .mis_cnt(s_mis_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  // Advance one clock, then settle 1 time unit past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] rd, input logic [31:0] nxt, input logic corr,
                       input logic ics, input logic hz);
    ic_rdata     = rd;
    bp_pc_next   = nxt;
    bp_correct   = corr;
    ic_stall     = ics;
    hazard_stall = hz;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(NOP, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc();
    check("rst_stall_out", 32'(stall_out), 32'd1);
    check("rst_branch_if", 32'(branch_if), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_inst", id_inst, NOP);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_br_cnt", 32'(br_cnt), 32'd0);
    check("rst_mis_cnt", 32'(mis_cnt), 32'd0);

    // BOOT: fetch request out, PC not updated on the following edge
    rst_n = 1'b1;
    drive(W0, 32'h4, 1'b1, 1'b0, 1'b0);
    check("boot_ic_addr", ic_addr, 32'h0);
    check("boot_ic_req", 32'(ic_req), 32'd1);
    check("boot_stall_out", 32'(stall_out), 32'd1);
    cyc();
    drive(W0, 32'h4, 1'b1, 1'b0, 1'b0);
    check("run0_ic_addr", ic_addr, 32'h0);
    check("run0_stall_out", 32'(stall_out), 32'd0);
    check("run0_branch_if", 32'(branch_if), 32'd0);
    check("run0_pc_add_4", pc_add_4, 32'h4);

    // sequential fetch
    cyc();
    check("seq1_ic_addr", ic_addr, 32'h4);
    check("seq1_id_inst", id_inst, W0);
    check("seq1_id_pc", id_pc, 32'h0);
    check("seq1_id_valid", 32'(id_valid), 32'd1);
    drive(W1, 32'h8, 1'b1, 1'b0, 1'b0);
    check("seq1_branch_if", 32'(branch_if), 32'd0);
    cyc();
    check("seq2_ic_addr", ic_addr, 32'h8);
    check("seq2_id_inst", id_inst, W1);
    drive(W2, 32'h10, 1'b1, 1'b0, 1'b0);
    check("seq2_branch_if", 32'(branch_if), 32'd0);
    cyc();
    check("seq3_id_inst", id_inst, W2);
    check("seq3_id_pc", id_pc, 32'h8);

    // BEQ at 0x10 predicted taken
    drive(BEQ, 32'h30, 1'b1, 1'b0, 1'b0);
    check("beq_branch_if", 32'(branch_if), 32'd1);
    check("beq_pc_add_imm", pc_add_imm, 32'h30);
    check("beq_pc_add_4", pc_add_4, 32'h14);
    cyc();
    check("beq_pc_loaded", ic_addr, 32'h30);
    check("beq_branch_id", 32'(branch_id), 32'd1);

    // mispredict resolves to fall-through
    drive(W3, 32'h14, 1'b0, 1'b0, 1'b0);
    cyc();
    check("mis_ic_addr", ic_addr, 32'h14);
    check("mis_id_inst", id_inst, NOP);
    check("mis_id_valid", 32'(id_valid), 32'd0);
    check("mis_br_cnt", 32'(br_cnt), 32'd1);
    check("mis_mis_cnt", 32'(mis_cnt), 32'd1);

    // cache miss for 3 cycles at 0x40
    drive(W4, 32'h40, 1'b1, 1'b0, 1'b0);
    cyc();
    check("pre_miss_id_inst", id_inst, W4);
    for (int i = 0; i < 3; i++) begin
      drive(JNK, 32'h99, 1'b1, 1'b1, 1'b0);
      check("miss_ic_addr", ic_addr, 32'h40);
      check("miss_branch_if", 32'(branch_if), 32'd0);
      check("miss_stall_out", 32'(stall_out), 32'd1);
      check("miss_id_inst", id_inst, W4);
      cyc();
    end
    drive(W5, 32'h44, 1'b1, 1'b0, 1'b0);
    check("miss_exit_stall_out", 32'(stall_out), 32'd1);
    check("miss_exit_ic_addr", ic_addr, 32'h40);
    cyc();
    check("miss_adv_ic_addr", ic_addr, 32'h44);
    check("miss_adv_id_inst", id_inst, W5);
    check("miss_adv_id_pc", id_pc, 32'h40);

    // mispredict held by hazard_stall, consumed when it drops
    drive(BEQ, 32'h64, 1'b1, 1'b0, 1'b0);
    check("b2_pc_add_imm", pc_add_imm, 32'h64);
    cyc();
    drive(W3, 32'h48, 1'b0, 1'b0, 1'b1);
    cyc();
    check("hz_ic_addr", ic_addr, 32'h64);
    check("hz_id_valid", 32'(id_valid), 32'd1);
    check("hz_id_pc", id_pc, 32'h44);
    check("hz_br_cnt", 32'(br_cnt), 32'd1);
    drive(W3, 32'h48, 1'b0, 1'b0, 1'b0);
    cyc();
    check("hz_rel_ic_addr", ic_addr, 32'h48);
    check("hz_rel_id_valid", 32'(id_valid), 32'd0);
    check("hz_rel_br_cnt", 32'(br_cnt), 32'd2);
    check("hz_rel_mis_cnt", 32'(mis_cnt), 32'd2);

    // two more mispredicts: narrow counters saturate at 3
    drive(BEQ, 32'h68, 1'b1, 1'b0, 1'b0);
    cyc();
    drive(W3, 32'h4C, 1'b0, 1'b0, 1'b0);
    cyc();
    check("m3_sat_br_cnt", 32'(s_br_cnt), 32'd3);
    check("m3_sat_mis_cnt", 32'(s_mis_cnt), 32'd3);
    drive(BEQ, 32'h6C, 1'b1, 1'b0, 1'b0);
    cyc();
    drive(W3, 32'h50, 1'b0, 1'b0, 1'b0);
    cyc();
    check("m4_br_cnt", 32'(br_cnt), 32'd4);
    check("m4_mis_cnt", 32'(mis_cnt), 32'd4);
    check("sat_br_cnt", 32'(s_br_cnt), 32'd3);
    check("sat_mis_cnt", 32'(s_mis_cnt), 32'd3);
    check("sat_ic_addr", s_ic_addr, 32'h50);
    check("sat_ic_req", 32'(s_ic_req), 32'd1);
    check("sat_id_inst", s_id_inst, NOP);
    check("sat_id_pc", s_id_pc, 32'h6C);
    check("sat_id_valid", 32'(s_id_valid), 32'd0);
    check("sat_branch_id", 32'(s_branch_id), 32'd0);

    // PC wrap-around
    drive(BEQ, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    check("sat_branch_if", 32'(s_branch_if), 32'd1);
    check("sat_stall_out", 32'(s_stall_out), 32'd0);
    check("sat_pc_add_4", s_pc_add_4, 32'h54);
    check("sat_pc_add_imm", s_pc_add_imm, 32'h70);
    cyc();
    drive(BEQ, 32'h0, 1'b1, 1'b0, 1'b0);
    check("wrap_ic_addr", ic_addr, 32'hFFFF_FFFC);
    check("wrap_pc_add_4", pc_add_4, 32'h0);
    check("wrap_pc_add_imm", pc_add_imm, 32'h1C);
    check("wrap_branch_id", 32'(branch_id), 32'd1);

    // reset in the middle of a miss
    drive(JNK, 32'h80, 1'b1, 1'b1, 1'b0);
    cyc();
    check("rmiss_ic_addr", ic_addr, 32'hFFFF_FFFC);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    drive(W0, 32'h4, 1'b1, 1'b0, 1'b0);
    check("rmiss_boot_ic_addr", ic_addr, 32'h0);
    check("rmiss_boot_stall_out", 32'(stall_out), 32'd1);
    check("rmiss_id_valid", 32'(id_valid), 32'd0);
    check("rmiss_br_cnt", 32'(br_cnt), 32'd0);
    cyc();
    check("rmiss_run_ic_addr", ic_addr, 32'h0);
    cyc();
    check("rmiss_adv_ic_addr", ic_addr, 32'h4);
    check("rmiss_adv_id_inst", id_inst, W0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RV32I core. It sits directly upstream of the branch predictor. It holds the program counter, drives the instruction-cache request, and pre-decodes conditional branches in IF. It produces `branch_if`, `pc_add_4` and `pc_add_imm` for the predictor, loads the predictor's next-PC every advancing cycle, squashes wrong-path fetches on mispredict, and fills the IF/ID pipeline register. It also keeps saturating branch and mispredict statistics counters.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_INST`, default 32'h0000_0013: bubble inserted into IF/ID (`addi x0,x0,0`).
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ic_addr` out 32: fetch address, equal to the PC register.
- `ic_req` out 1: fetch request.
- `ic_rdata` in 32: instruction word, valid when `ic_stall`=0.
- `ic_stall` in 1: cache miss; hold everything.
- `hazard_stall` in 1: ID-stage load-use stall; hold PC and IF/ID.
- `bp_pc_next` in 32: next PC from the predictor.
- `bp_correct` in 1: 0 means the branch in ID was mispredicted.
- `branch_if` out 1: IF holds a valid conditional branch.
- `branch_id` out 1: IF/ID holds a valid conditional branch.
- `pc_add_4` out 32: PC + 4.
- `pc_add_imm` out 32: PC + B-immediate.
- `stall_out` out 1: `ic_stall | hazard_stall | (state != RUN)`, fed to the predictor.
- `id_inst` out 32: IF/ID instruction.
- `id_pc` out 32: IF/ID PC.
- `id_valid` out 1: IF/ID valid.
- `br_cnt` out CNT_W: resolved branches, saturating.
- `mis_cnt` out CNT_W: mispredicts, saturating.

## Operation
- FSM has three states:
  - BOOT: first cycle after reset. `ic_req`=1, PC is not updated. Always goes to RUN next.
  - RUN: normal fetch. Goes to MISS when `ic_stall`=1.
  - MISS: waiting on the cache. Goes back to RUN the first cycle `ic_stall`=0; that cycle advances like RUN.
- `ic_req`=1 in every state except reset.
- Pre-decode is valid only in RUN/MISS with `ic_stall`=0:
  - `branch_if` = (`ic_rdata[6:0]`==7'b1100011).
  - B-immediate is sign-extended `{inst[31],inst[7],inst[30:25],inst[11:8],0}`.
  - `pc_add_imm` = PC + imm, mod 2^32.
  - `pc_add_4` = PC + 4, mod 2^32. Wrap-around is silent.
- Advance condition: state is RUN (or MISS exiting) and `ic_stall`=0 and `hazard_stall`=0. On advance:
  - PC <= `bp_pc_next`.
  - If IF/ID holds a branch and `bp_correct`=0: IF/ID <= {NOP_INST, PC, valid=0}. The IF word is wrong-path.
  - Otherwise: IF/ID <= {`ic_rdata`, PC, valid=1}.
- Not advancing: PC and IF/ID hold. `branch_if` is forced 0 while `ic_stall`=1.
- Counters increment once per advancing cycle in which `branch_id`=1:
  - `br_cnt` increments every such cycle.
  - `mis_cnt` increments additionally when `bp_correct`=0.
  - Both saturate at all-ones.
- A mispredict arriving with `hazard_stall`=1 is not consumed. It is re-evaluated when the stall drops, because the predictor holds `correct` stable under stall.

## Timing
- Reset values:
  - PC = RESET_PC.
  - state = BOOT.
  - `id_inst` = NOP_INST, `id_pc` = 0, `id_valid` = 0.
  - `br_cnt` = `mis_cnt` = 0.
  - `branch_if` = 0, `stall_out` = 1.
- Reset mid-miss returns to BOOT and discards the pending fetch.
- Fetch-to-ID latency is 1 cycle after `ic_stall` falls.
- Mispredict penalty is exactly one bubble.
- Next-PC path: `ic_rdata` → pre-decode → predictor → `bp_pc_next` → PC register is combinational within one cycle. No combinational path from `bp_pc_next` to any output.
- Simultaneous `ic_stall` and mispredict: hold. Squash occurs on the advancing cycle.

## Structure
- Shared package `core_pkg`:
  - `OP_BRANCH`=7'b1100011.
  - `NOP_INST`.
  - The fetch FSM state enum.
  - Function `imm_b(inst)`.
- Sub-module `if_id_reg` holds the pipeline register with hold and squash inputs and a valid bit. The FSM, PC and counters stay in `fetch_stage`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles, then release. Required: `ic_addr`=0 in BOOT; `id_valid`=0; PC=4 after the first advancing cycle with `bp_pc_next`=4.
- Sequential fetch of 3 non-branch words at PC 0/4/8. Required: `id_inst` matches each word one cycle later; `branch_if`=0 throughout.
- BEQ at PC 0x10 with imm +0x20. Required: `branch_if`=1, `pc_add_imm`=0x30, `pc_add_4`=0x14; PC loads 0x30 from `bp_pc_next`.
- Mispredict: `bp_correct`=0 with `bp_pc_next`=0x14. Required: `id_inst`=0x13, `id_valid`=0, PC=0x14, `mis_cnt`=1, `br_cnt`=1.
- `ic_stall`=1 for 3 cycles at PC 0x40. Required: state MISS, PC/IF/ID held, `stall_out`=1; advances on the 4th cycle.
- Counters preloaded to 0xFFFF plus a further mispredict. Required: both remain 0xFFFF.
